// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared SIMON configuration constants and FSM state type
package simon_pkg;

  // SIMON128/128 is the default configuration
  localparam int SIMON128_WORD   = 64;
  localparam int SIMON128_ROUNDS = 68;

  // Alternate configurations: SIMON32/64-style 32-bit block and SIMON64/128
  localparam int SIMON32_WORD    = 16;
  localparam int SIMON32_ROUNDS  = 32;
  localparam int SIMON64_WORD    = 32;
  localparam int SIMON64_ROUNDS  = 44;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/simon_rotl.sv
// rtl/simon_rotl.sv - circular left rotation of one word by a fixed amount
module simon_rotl #(
  parameter int WORD_SIZE = 64,
  parameter int AMT       = 1
) (
  input  logic [WORD_SIZE-1:0] din,
  output logic [WORD_SIZE-1:0] dout
);

  assign dout = {din[WORD_SIZE-1-AMT:0], din[WORD_SIZE-1:WORD_SIZE-AMT]};

endmodule

// File: rtl/simon_round_fn.sv
// rtl/simon_round_fn.sv - one combinational SIMON Feistel round
module simon_round_fn #(
  parameter int WORD_SIZE = 64
) (
  input  logic [WORD_SIZE-1:0] x,
  input  logic [WORD_SIZE-1:0] y,
  input  logic [WORD_SIZE-1:0] rk,
  output logic [WORD_SIZE-1:0] x_next,
  output logic [WORD_SIZE-1:0] y_next
);

  logic [WORD_SIZE-1:0] x_r1;
  logic [WORD_SIZE-1:0] x_r8;
  logic [WORD_SIZE-1:0] x_r2;

  simon_rotl #(.WORD_SIZE(WORD_SIZE), .AMT(1)) u_rot1 (.din(x), .dout(x_r1));
  simon_rotl #(.WORD_SIZE(WORD_SIZE), .AMT(8)) u_rot8 (.din(x), .dout(x_r8));
  simon_rotl #(.WORD_SIZE(WORD_SIZE), .AMT(2)) u_rot2 (.din(x), .dout(x_r2));

  // f(x) = (x<<<1 & x<<<8) ^ x<<<2, mixed with the other half and the round key
  assign x_next = y ^ ((x_r1 & x_r8) ^ x_r2) ^ rk;
  assign y_next = x;

endmodule

// File: rtl/simon_round_engine.sv
// rtl/simon_round_engine.sv - iterative SIMON encryptor, one round per key beat
module simon_round_engine
  import simon_pkg::*;
#(
  parameter int WORD_SIZE = SIMON128_WORD,
  parameter int ROUNDS    = SIMON128_ROUNDS,
  parameter int CNT_W     = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] pt_x,
  input  logic [WORD_SIZE-1:0] pt_y,
  input  logic [WORD_SIZE-1:0] rk,
  input  logic                 rk_valid,
  output logic                 rk_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] ct_x,
  output logic [WORD_SIZE-1:0] ct_y,
  output logic                 busy
);

  state_t               state;
  state_t               state_nxt;
  logic [WORD_SIZE-1:0] x;
  logic [WORD_SIZE-1:0] y;
  logic [CNT_W-1:0]     cnt;
  logic [WORD_SIZE-1:0] x_rnd;
  logic [WORD_SIZE-1:0] y_rnd;
  logic                 last_round;

  simon_round_fn #(.WORD_SIZE(WORD_SIZE)) u_round (
    .x      (x),
    .y      (y),
    .rk     (rk),
    .x_next (x_rnd),
    .y_next (y_rnd)
  );

  assign last_round = (cnt == CNT_W'(ROUNDS - 1));

  // The block registers double as the ciphertext holding register in DONE
  assign ct_x = x;
  assign ct_y = y;

  // Next-state and handshake outputs; everything is forced low while rst is held
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    rk_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        rk_ready = 1'b1;
        busy     = 1'b1;
        if (rk_valid && last_round) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      in_ready  = 1'b0;
      rk_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
    end
  end

  // State, block halves and round counter; a missing key simply holds everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        x   <= pt_x;
        y   <= pt_y;
        cnt <= '0;
      end else if (state == RUN && rk_valid) begin
        x   <= x_rnd;
        y   <= y_rnd;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_simon_round_engine.sv
// tb/tb_simon_round_engine.sv - randomized self-checking bench for simon_round_engine
module tb_simon_round_engine;

  localparam int NR = 68;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, rk_valid, rk_ready, out_valid, out_ready, busy;
  logic [63:0] pt_x, pt_y, rk, ct_x, ct_y;
  logic        in_valid1, in_ready1, rk_valid1, rk_ready1, out_valid1, out_ready1, busy1;
  logic [63:0] pt_x1, pt_y1, rk1, ct_x1, ct_y1;

  logic [63:0] keys [NR];
  logic [61:0] z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  int vectors = 0;
  int miscompares = 0;

  localparam logic [63:0] STD_K1 = 64'h0f0e0d0c0b0a0908;
  localparam logic [63:0] STD_K0 = 64'h0706050403020100;
  localparam logic [63:0] STD_PX = 64'h6373656420737265;
  localparam logic [63:0] STD_PY = 64'h6c6c657661727420;
  localparam logic [63:0] STD_CX = 64'h49681b1e1e54fe3f;
  localparam logic [63:0] STD_CY = 64'h65aa832af84e0bbc;

  always #5 clk = ~clk;

  simon_round_engine dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pt_x(pt_x), .pt_y(pt_y), .rk(rk), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .out_valid(out_valid), .out_ready(out_ready), .ct_x(ct_x), .ct_y(ct_y), .busy(busy)
  );

  simon_round_engine #(.WORD_SIZE(64), .ROUNDS(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .pt_x(pt_x1), .pt_y(pt_y1), .rk(rk1), .rk_valid(rk_valid1), .rk_ready(rk_ready1),
    .out_valid(out_valid1), .out_ready(out_ready1), .ct_x(ct_x1), .ct_y(ct_y1), .busy(busy1)
  );

  function automatic logic [63:0] rotl(input logic [63:0] v, input int r);
    return (v << r) | (v >> (64 - r));
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] v, input int r);
    return (v >> r) | (v << (64 - r));
  endfunction

  // SIMON128/128 key expansion (m = 2, constant sequence z2)
  task automatic expand_key(input logic [63:0] k1, input logic [63:0] k0);
    logic [63:0] tmp;
    keys[0] = k0;
    keys[1] = k1;
    for (int i = 2; i < NR; i++) begin
      tmp = rotr(keys[i-1], 3);
      tmp = tmp ^ rotr(tmp, 1);
      keys[i] = ~keys[i-2] ^ tmp ^ {63'd0, z2[61 - ((i - 2) % 62)]} ^ 64'd3;
    end
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [63:0] px, input logic [63:0] py);
    logic [63:0] a, b, t;
    a = px;
    b = py;
    for (int i = 0; i < NR; i++) begin
      t = b ^ ((rotl(a, 1) & rotl(a, 8)) ^ rotl(a, 2)) ^ keys[i];
      b = a;
      a = t;
    end
    return {a, b};
  endfunction

  // Push one block through the main engine with nstall key gaps and hold cycles of backpressure
  task automatic run_block(input logic [63:0] px, input logic [63:0] py, input int nstall,
                           input int hold, input logic [63:0] ex, input logic [63:0] ey,
                           input string name);
    int lat, kidx, stalls, guard;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL %s in_ready_before_accept got=%b want=1", name, in_ready);
    end
    in_valid = 1'b1; pt_x = px; pt_y = py; out_ready = 1'b0;
    rk_valid = 1'b1; rk = {$urandom, $urandom};
    @(posedge clk);
    lat = 0; kidx = 0; stalls = nstall; guard = 0;
    while (guard < 1000) begin
      @(negedge clk);
      if (out_valid === 1'b1) break;
      guard++;
      vectors++;
      if (rk_ready !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL %s run_handshake rk_ready=%b in_ready=%b busy=%b want 1/0/1", name, rk_ready, in_ready, busy);
      end
      in_valid = 1'($urandom_range(0, 1));
      pt_x = {$urandom, $urandom};
      pt_y = {$urandom, $urandom};
      if (stalls > 0 && ($urandom_range(0, 3) == 0 || kidx == NR - 1)) begin
        rk_valid = 1'b0; stalls--;
      end else begin
        rk_valid = 1'b1;
      end
      rk = rk_valid ? keys[kidx % NR] : {$urandom, $urandom};
      @(posedge clk);
      lat++;
      if (rk_valid) kidx++;
    end
    in_valid = 1'b0;
    vectors++;
    if (guard >= 1000) begin
      miscompares++; $display("FAIL %s out_valid_timeout waited=%0d cycles", name, guard);
    end
    vectors++;
    if (lat != NR + nstall) begin
      miscompares++; $display("FAIL %s latency got=%0d want=%0d", name, lat, NR + nstall);
    end
    vectors++;
    if (ct_x !== ex || ct_y !== ey) begin
      miscompares++; $display("FAIL %s ciphertext got=%h_%h want=%h_%h", name, ct_x, ct_y, ex, ey);
    end
    for (int h = 0; h < hold; h++) begin
      rk_valid = 1'b1; rk = {$urandom, $urandom};
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || rk_ready !== 1'b0 || ct_x !== ex || ct_y !== ey) begin
        miscompares++;
        $display("FAIL %s done_hold out_valid=%b in_ready=%b rk_ready=%b ct=%h_%h want 1/0/0 %h_%h",
                 name, out_valid, in_ready, rk_ready, ct_x, ct_y, ex, ey);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0; rk_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL %s release out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 0; pt_x = 0; pt_y = 0; rk = 0; rk_valid = 0; out_ready = 0;
    in_valid1 = 0; pt_x1 = 0; pt_y1 = 0; rk1 = 0; rk_valid1 = 0; out_ready1 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (in_ready !== 0 || out_valid !== 0 || rk_ready !== 0 || busy !== 0) begin
      miscompares++; $display("FAIL reset_ctrl in_ready=%b out_valid=%b rk_ready=%b busy=%b want 0", in_ready, out_valid, rk_ready, busy);
    end
    vectors++;
    if (ct_x !== 64'd0 || ct_y !== 64'd0) begin
      miscompares++; $display("FAIL reset_ct got=%h_%h want=0_0", ct_x, ct_y);
    end
    vectors++;
    if (in_ready1 !== 0 || out_valid1 !== 0 || ct_x1 !== 64'd0) begin
      miscompares++; $display("FAIL reset_dut1 in_ready=%b out_valid=%b ct_x=%h want 0", in_ready1, out_valid1, ct_x1);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || in_ready1 !== 1'b1) begin
      miscompares++; $display("FAIL reset_release in_ready=%b/%b want 1/1", in_ready, in_ready1);
    end
  endtask

  task automatic test_single_round();
    in_valid1 = 1; pt_x1 = 64'd1; pt_y1 = 64'd0; rk1 = 64'd0; rk_valid1 = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 0;
    vectors++;
    if (out_valid1 !== 1'b0 || busy1 !== 1'b1) begin
      miscompares++; $display("FAIL single_run out_valid=%b busy=%b want 0/1", out_valid1, busy1);
    end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (out_valid1 !== 1'b1 || ct_x1 !== 64'h4 || ct_y1 !== 64'h1) begin
      miscompares++; $display("FAIL single_round out_valid=%b ct=%h_%h want 1 4_1", out_valid1, ct_x1, ct_y1);
    end
    out_ready1 = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready1 = 0; rk_valid1 = 0;
    vectors++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
      miscompares++; $display("FAIL single_release in_ready=%b out_valid=%b want 1/0", in_ready1, out_valid1);
    end
  endtask

  task automatic test_all_zero();
    for (int i = 0; i < NR; i++) keys[i] = 64'd0;
    run_block(64'd0, 64'd0, 0, 0, 64'd0, 64'd0, "all_zero");
  endtask

  task automatic test_std_vector();
    expand_key(STD_K1, STD_K0);
    run_block(STD_PX, STD_PY, 0, 0, STD_CX, STD_CY, "std_vector");
  endtask

  task automatic test_key_stall();
    expand_key(STD_K1, STD_K0);
    run_block(STD_PX, STD_PY, 20, 0, STD_CX, STD_CY, "key_stall");
  endtask

  task automatic test_backpressure();
    expand_key(STD_K1, STD_K0);
    run_block(STD_PX, STD_PY, 0, 10, STD_CX, STD_CY, "backpressure");
  endtask

  task automatic test_mid_reset();
    expand_key(STD_K1, STD_K0);
    @(negedge clk);
    in_valid = 1; pt_x = STD_PX; pt_y = STD_PY; rk_valid = 1; rk = keys[0];
    @(posedge clk);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      in_valid = 0; rk_valid = 1; rk = keys[k];
      @(posedge clk);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (out_valid !== 0 || busy !== 0 || rk_ready !== 0 || in_ready !== 0 || ct_x !== 64'd0 || ct_y !== 64'd0) begin
      miscompares++;
      $display("FAIL mid_reset out_valid=%b busy=%b rk_ready=%b in_ready=%b ct=%h_%h want all 0",
               out_valid, busy, rk_ready, in_ready, ct_x, ct_y);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || rk_ready !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset_idle in_ready=%b busy=%b rk_ready=%b want 1/0/0", in_ready, busy, rk_ready);
    end
    rk_valid = 0;
    run_block(STD_PX, STD_PY, 0, 0, STD_CX, STD_CY, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp;
    logic [63:0]  px, py;
    for (int b = 0; b < 4; b++) begin
      expand_key({$urandom, $urandom}, {$urandom, $urandom});
      px = {$urandom, $urandom};
      py = {$urandom, $urandom};
      exp = ref_encrypt(px, py);
      run_block(px, py, $urandom_range(0, 5), $urandom_range(0, 3), exp[127:64], exp[63:0], "random_block");
    end
  endtask

  initial begin
    test_reset();
    test_single_round();
    test_all_zero();
    test_std_vector();
    test_key_stall();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
